// File: rtl/mac_array_drain.sv
// Result-side reader for the 2x2 MAC array: captures per-lane accumulators,
// clears each MAC, buffers whole frames and streams them as requantized words.
module mac_array_drain #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  output logic [N_MACS-1:0]       clear_out,
  output logic signed [OUT_W-1:0] m_data,
  output logic [1:0]              m_idx,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    overflow,
  output logic                    sat_seen,
  output logic                    busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [ACC_W-1:0] P_QMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] P_QMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, SEND} state_t;

  logic signed [ACC_W-1:0] w_acc [N_MACS];
  logic signed [ACC_W-1:0] r_stage [N_MACS];
  logic signed [ACC_W-1:0] r_fifo [DEPTH][N_MACS];
  logic [N_MACS-1:0]       r_held;
  logic [N_MACS-1:0]       r_vinD;
  logic [N_MACS-1:0]       w_heldEff;
  logic [N_MACS-1:0]       w_cap;
  logic [N_MACS-1:0]       w_drop;
  logic [PW-1:0]           r_wrPtr;
  logic [PW-1:0]           r_rdPtr;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           w_countNext;
  logic                    w_full;
  logic                    w_commit;
  logic                    w_pop;
  state_t                  r_state;
  logic [1:0]              r_idx;
  logic signed [ACC_W-1:0] w_head;
  logic signed [ACC_W-1:0] w_shifted;
  logic                    w_satHi;
  logic                    w_satLo;
  logic signed [OUT_W-1:0] w_q;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_acc[0] = acc_in_0;
  assign w_acc[1] = acc_in_1;
  assign w_acc[2] = acc_in_2;
  assign w_acc[3] = acc_in_3;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = (r_state == SEND) && m_ready && (r_idx == 2'd3);
  assign w_commit = (&r_held) && (!w_full || w_pop);

  // On the commit edge every lane is free again, so a new result lands in the next frame.
  assign w_heldEff = w_commit ? '0 : r_held;
  assign w_cap     = valid_in & ~w_heldEff;
  assign w_drop    = valid_in & ~r_vinD & w_heldEff;

  always_comb begin
    w_countNext = r_count;
    case ({w_commit, w_pop})
      2'b10:   w_countNext = r_count + CW'(1);
      2'b01:   w_countNext = r_count - CW'(1);
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_held    <= '0;
      r_vinD    <= '0;
      clear_out <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < N_MACS; i++) r_stage[i] <= '0;
    end else begin
      r_vinD    <= valid_in;
      clear_out <= w_cap;
      r_held    <= w_heldEff | w_cap;
      for (int i = 0; i < N_MACS; i++) begin
        if (w_cap[i]) r_stage[i] <= w_acc[i];
      end
      if (|w_drop) overflow <= 1'b1;
    end
  end

  // Frame storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < N_MACS; i++) r_fifo[r_wrPtr][i] <= r_stage[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_commit) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_pop)    r_rdPtr <= nextPtr(r_rdPtr);
      r_count <= w_countNext;
    end
  end

  assign w_head    = r_fifo[r_rdPtr][r_idx];
  assign w_shifted = w_head >>> SHIFT;
  assign w_satHi   = (w_shifted > P_QMAX);
  assign w_satLo   = (w_shifted < P_QMIN);
  assign w_q       = w_satHi ? P_QMAX[OUT_W-1:0] :
                     w_satLo ? P_QMIN[OUT_W-1:0] : w_shifted[OUT_W-1:0];

  // IDLE looks at the commit itself so the first beat appears right after the commit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_idx    <= 2'd0;
      sat_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idx <= 2'd0;
          if (w_commit || (r_count != '0)) r_state <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            if (w_satHi || w_satLo) sat_seen <= 1'b1;
            if (r_idx != 2'd3) begin
              r_idx <= r_idx + 2'd1;
            end else begin
              r_idx   <= 2'd0;
              r_state <= (w_countNext != '0) ? SEND : IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_valid = (r_state == SEND);
  assign m_data  = m_valid ? w_q : '0;
  assign m_idx   = r_idx;
  assign m_last  = m_valid && (r_idx == 2'd3);
  assign busy    = (|r_held) || (r_count != '0);

endmodule

// File: tb/tb_mac_array_drain.sv
// Directed bench for mac_array_drain: stimulus pushes hand-computed words into
// a scoreboard queue, a negedge monitor pops and compares on every handshake.
module tb_mac_array_drain;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] acc0, acc1, acc2, acc3;
  logic [3:0]         validIn;
  logic               mReady;

  logic [3:0]         clear_out, clear_out4;
  logic signed [7:0]  m_data, m_data4;
  logic [1:0]         m_idx, m_idx4;
  logic               m_last, m_last4, m_valid, m_valid4;
  logic               overflow, overflow4, sat_seen, sat_seen4, busy, busy4;

  typedef struct packed {
    logic signed [7:0] d;
    logic [1:0]        i;
    logic              l;
  } word_t;

  word_t sb[$];
  word_t sb4[$];
  word_t monW, monW4, prevWord;
  bit    prevStall = 1'b0;
  bit    t4Active  = 1'b0;
  int    vectors     = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  mac_array_drain #(.ACC_W(16), .N_MACS(4), .OUT_W(8), .SHIFT(0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
    .valid_in(validIn), .clear_out(clear_out),
    .m_data(m_data), .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid), .m_ready(mReady),
    .overflow(overflow), .sat_seen(sat_seen), .busy(busy)
  );

  mac_array_drain #(.ACC_W(16), .N_MACS(4), .OUT_W(8), .SHIFT(4), .DEPTH(2)) dut4 (
    .clk(clk), .rst(rst),
    .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
    .valid_in(validIn), .clear_out(clear_out4),
    .m_data(m_data4), .m_idx(m_idx4), .m_last(m_last4), .m_valid(m_valid4), .m_ready(mReady),
    .overflow(overflow4), .sat_seen(sat_seen4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit to4, input int d, input int i);
    word_t w;
    w.d = 8'(d);
    w.i = 2'(i);
    w.l = (i == 3);
    if (to4) sb4.push_back(w);
    else     sb.push_back(w);
  endtask

  task automatic expectFrame(input bit to4, input int d0, input int d1, input int d2, input int d3);
    pushExp(to4, d0, 0);
    pushExp(to4, d1, 1);
    pushExp(to4, d2, 2);
    pushExp(to4, d3, 3);
  endtask

  task automatic applyStimulus(input logic [3:0] v, input int a0, input int a1, input int a2, input int a3);
    acc0    = 16'(a0);
    acc1    = 16'(a1);
    acc2    = 16'(a2);
    acc3    = 16'(a3);
    validIn = v;
  endtask

  task automatic pulseFrame(input int a0, input int a1, input int a2, input int a3);
    applyStimulus(4'b1111, a0, a1, a2, a3);
    tick();
    validIn = 4'b0000;
    tick();
    tick();
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n = 0;
    while ((sb.size() != 0 || sb4.size() != 0) && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput({name, " drain left"}, sb.size() + sb4.size(), 0);
  endtask

  // Scoreboard monitor for the SHIFT=0 instance, plus stall-stability of the held word.
  always @(negedge clk) begin
    if (!rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall && m_valid)
        checkOutput("stall stable", int'({m_data, m_idx, m_last}), int'(prevWord));
      if (m_valid && mReady) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected word: got %0d idx %0d expected none", m_data, m_idx);
        end else begin
          monW = sb.pop_front();
          checkOutput("stream data", m_data, monW.d);
          checkOutput("stream idx", m_idx, monW.i);
          checkOutput("stream last", m_last, monW.l);
        end
      end
      prevStall  = m_valid && !mReady;
      prevWord.d = m_data;
      prevWord.i = m_idx;
      prevWord.l = m_last;
    end
  end

  always @(negedge clk) begin
    if (rst && t4Active && m_valid4 && mReady) begin
      if (sb4.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected shifted word: got %0d expected none", m_data4);
      end else begin
        monW4 = sb4.pop_front();
        checkOutput("shift4 data", m_data4, monW4.d);
        checkOutput("shift4 idx", m_idx4, monW4.i);
      end
    end
  end

  initial begin
    int beats;
    mReady = 1'b0;
    applyStimulus(4'b0000, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("reset clear_out", clear_out, 0);
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset m_idx", m_idx, 0);
    checkOutput("reset m_last", m_last, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset sat_seen", sat_seen, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b1;
    tick();

    // T1: single-cycle valid on all lanes, saturation at both rails
    mReady = 1'b1;
    expectFrame(0, 100, -5, 127, -128);
    applyStimulus(4'b1111, 100, -5, 300, -300);
    tick();
    validIn = 4'b0000;
    checkOutput("T1 clear_out", clear_out, 4'hF);
    checkOutput("T1 m_valid before commit", m_valid, 0);
    tick();
    checkOutput("T1 m_valid after commit", m_valid, 1);
    checkOutput("T1 first idx", m_idx, 0);
    waitDrain("T1", 50);
    checkOutput("T1 sat_seen", sat_seen, 1);
    checkOutput("T1 overflow", overflow, 0);
    checkOutput("T1 idle", m_valid, 0);

    // T2: skewed lane completion
    expectFrame(0, 10, 20, 30, 40);
    applyStimulus(4'b0001, 10, 20, 30, 40);
    tick();
    checkOutput("T2 clear t+1", clear_out, 4'b0001);
    validIn = 4'b0110;
    tick();
    checkOutput("T2 clear t+2", clear_out, 4'b0110);
    validIn = 4'b1000;
    tick();
    checkOutput("T2 clear t+3", clear_out, 4'b1000);
    checkOutput("T2 m_valid t+3", m_valid, 0);
    validIn = 4'b0000;
    tick();
    checkOutput("T2 m_valid t+4", m_valid, 1);
    waitDrain("T2", 50);
    repeat (3) tick();
    checkOutput("T2 single frame", m_valid, 0);
    checkOutput("T2 busy", busy, 0);

    // T3: back-pressure, full FIFO, staged frame, dropped lane
    mReady = 1'b0;
    expectFrame(0, 1, 2, 3, 4);
    pulseFrame(1, 2, 3, 4);
    expectFrame(0, 5, 6, 7, 8);
    pulseFrame(5, 6, 7, 8);
    expectFrame(0, 9, 10, 11, 12);
    pulseFrame(9, 10, 11, 12);
    checkOutput("T3 busy", busy, 1);
    checkOutput("T3 head data", m_data, 1);
    checkOutput("T3 overflow before drop", overflow, 0);
    applyStimulus(4'b0001, 99, 0, 0, 0);
    tick();
    validIn = 4'b0000;
    checkOutput("T3 no clear on drop", clear_out, 0);
    checkOutput("T3 overflow", overflow, 1);
    repeat (3) tick();
    mReady = 1'b1;
    waitDrain("T3", 100);
    checkOutput("T3 overflow sticky", overflow, 1);
    checkOutput("T3 busy after", busy, 0);

    // T5: reset in the middle of a frame
    mReady = 1'b0;
    expectFrame(0, 11, 22, 33, 44);
    applyStimulus(4'b1111, 11, 22, 33, 44);
    tick();
    validIn = 4'b0000;
    tick();
    mReady = 1'b1;
    tick();
    tick();
    mReady = 1'b0;
    checkOutput("T5 idx before reset", m_idx, 2);
    rst = 1'b0;
    #1;
    checkOutput("T5 m_valid in reset", m_valid, 0);
    checkOutput("T5 m_idx in reset", m_idx, 0);
    checkOutput("T5 overflow in reset", overflow, 0);
    checkOutput("T5 busy in reset", busy, 0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();
    mReady = 1'b1;
    expectFrame(0, 55, 66, 77, 88);
    applyStimulus(4'b1111, 55, 66, 77, 88);
    tick();
    validIn = 4'b0000;
    waitDrain("T5", 50);
    checkOutput("T5 busy after", busy, 0);

    // T6: pop of a full FIFO coincides with the staged commit
    mReady = 1'b0;
    expectFrame(0, 21, 22, 23, 24);
    pulseFrame(21, 22, 23, 24);
    expectFrame(0, 25, 26, 27, 28);
    pulseFrame(25, 26, 27, 28);
    expectFrame(0, 29, 30, 31, 32);
    pulseFrame(29, 30, 31, 32);
    mReady = 1'b1;
    beats = 0;
    repeat (12) begin
      if (m_valid) beats++;
      tick();
    end
    checkOutput("T6 beats without bubble", beats, 12);
    waitDrain("T6", 20);
    checkOutput("T6 idle", m_valid, 0);
    checkOutput("T6 overflow", overflow, 0);
    checkOutput("T6 sat_seen", sat_seen, 0);
    checkOutput("T6 busy", busy, 0);

    // T4: arithmetic shift by 4 on the second instance
    t4Active = 1'b1;
    expectFrame(0, 127, -128, 127, 0);
    expectFrame(1, 18, -19, 127, 0);
    applyStimulus(4'b1111, 291, -291, 32767, 0);
    tick();
    validIn = 4'b0000;
    waitDrain("T4", 50);
    t4Active = 1'b0;
    checkOutput("T4 sat_seen shift4", sat_seen4, 1);
    checkOutput("T4 sat_seen shift0", sat_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
